// File: rtl/genie_pkg.sv
// genie_pkg: code-word bit layout, decoder FSM states and character classification
// shared by the Game Genie text decoder and its pack stage.
package genie_pkg;

  localparam int unsigned STROBE  = 34;
  localparam int unsigned ENABLE  = 33;
  localparam int unsigned CMP_EN  = 32;
  localparam int unsigned ADDR_HI = 31;
  localparam int unsigned ADDR_LO = 16;
  localparam int unsigned CMP_HI  = 15;
  localparam int unsigned CMP_LO  = 8;
  localparam int unsigned REPL_HI = 7;
  localparam int unsigned REPL_LO = 0;

  typedef enum logic [1:0] {COLLECT, DISCARD, EMIT, GAP} state_t;

  // Returns {is_letter, nibble}; lower-case letters fold onto upper case.
  function automatic logic [4:0] letter_nib(input logic [7:0] c);
    logic [7:0] u;
    u = ((c >= 8'h61) && (c <= 8'h7A)) ? (c - 8'h20) : c;
    case (u)
      "A":     letter_nib = {1'b1, 4'd0};
      "P":     letter_nib = {1'b1, 4'd1};
      "Z":     letter_nib = {1'b1, 4'd2};
      "L":     letter_nib = {1'b1, 4'd3};
      "G":     letter_nib = {1'b1, 4'd4};
      "I":     letter_nib = {1'b1, 4'd5};
      "T":     letter_nib = {1'b1, 4'd6};
      "Y":     letter_nib = {1'b1, 4'd7};
      "E":     letter_nib = {1'b1, 4'd8};
      "O":     letter_nib = {1'b1, 4'd9};
      "X":     letter_nib = {1'b1, 4'd10};
      "U":     letter_nib = {1'b1, 4'd11};
      "K":     letter_nib = {1'b1, 4'd12};
      "S":     letter_nib = {1'b1, 4'd13};
      "V":     letter_nib = {1'b1, 4'd14};
      "N":     letter_nib = {1'b1, 4'd15};
      default: letter_nib = 5'd0;
    endcase
  endfunction

  function automatic logic is_term(input logic [7:0] c);
    return (c == 8'h00) || (c == 8'h0A) || (c == 8'h0D) ||
           (c == 8'h20) || (c == 8'h2C) || (c == 8'h3B);
  endfunction

endpackage

// File: rtl/genie_code_pack.sv
// genie_code_pack: combinational scramble of 8 letter nibbles into the
// CPU address, compare and replace bytes of a Game Genie code.
module genie_code_pack
  import genie_pkg::*;
#(
  parameter logic [15:0] ADDR_BASE = 16'h8000
) (
  input  logic [7:0][3:0] i_nib,
  input  logic            i_len8,
  output logic [15:0]     o_addr,
  output logic [7:0]      o_compare,
  output logic [7:0]      o_replace
);

  logic [3:0] w_l;

  always_comb begin
    w_l    = i_len8 ? i_nib[7] : i_nib[5];
    o_addr = ADDR_BASE
           | (16'(i_nib[3] & 4'h7) << 12)
           | (16'(i_nib[5] & 4'h7) << 8)
           | (16'(i_nib[4] & 4'h8) << 8)
           | (16'(i_nib[2] & 4'h7) << 4)
           | (16'(i_nib[1] & 4'h8) << 4)
           |  16'(i_nib[4] & 4'h7)
           |  16'(i_nib[3] & 4'h8);
    o_replace = (8'(i_nib[1] & 4'h7) << 4)
              | (8'(i_nib[0] & 4'h8) << 4)
              |  8'(i_nib[0] & 4'h7)
              |  8'(w_l & 4'h8);
    o_compare = '0;
    if (i_len8) begin
      o_compare = (8'(i_nib[7] & 4'h7) << 4)
                | (8'(i_nib[6] & 4'h8) << 4)
                |  8'(i_nib[6] & 4'h7)
                |  8'(i_nib[5] & 4'h8);
    end
  end

endmodule

// File: rtl/genie_code_decoder.sv
// genie_code_decoder: ASCII Game Genie text stream -> 38-bit code-table word.
// Define GENIE_DEC_STATS_EN to add saturating accepted/rejected counters.
module genie_code_decoder
  import genie_pkg::*;
#(
  parameter logic [15:0] ADDR_BASE = 16'h8000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chr_valid,
  input  logic [7:0]  chr_data,
  output logic        chr_ready,
  input  logic        flush,
  output logic [37:0] code,
  output logic        busy,
  output logic        err
`ifdef GENIE_DEC_STATS_EN
  ,
  output logic [7:0]  n_accepted,
  output logic [7:0]  n_rejected
`endif
);

  state_t          r_state, w_state_nxt;
  logic [3:0]      r_count;
  logic [7:0][3:0] r_nib;
  logic [37:0]     r_code;
  logic            r_err;

  logic       w_xfer, w_is_dash, w_let, w_term, w_bad, w_len8;
  logic       w_store, w_load, w_reject;
  logic [4:0] w_lookup;
  logic [15:0] w_addr;
  logic [7:0]  w_cmp, w_repl;

  assign chr_ready = (r_state == COLLECT) || (r_state == DISCARD);
  assign w_xfer    = chr_valid & chr_ready;
  assign w_lookup  = letter_nib(chr_data);
  assign w_is_dash = (chr_data == 8'h2D);
  assign w_let     = w_xfer & w_lookup[4];
  // A byte transfer takes precedence; flush only terminates on an idle cycle.
  assign w_term    = w_xfer ? is_term(chr_data) : flush;
  assign w_bad     = w_xfer & ~w_lookup[4] & ~w_is_dash & ~is_term(chr_data);
  assign w_len8    = (r_count == 4'd8);

  genie_code_pack #(.ADDR_BASE(ADDR_BASE)) u_pack (
    .i_nib     (r_nib),
    .i_len8    (w_len8),
    .o_addr    (w_addr),
    .o_compare (w_cmp),
    .o_replace (w_repl)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_store     = 1'b0;
    w_load      = 1'b0;
    w_reject    = 1'b0;
    case (r_state)
      COLLECT: begin
        if (w_term) begin
          if ((r_count == 4'd6) || w_len8) begin
            w_load      = 1'b1;
            w_state_nxt = EMIT;
          end else if (r_count != '0) begin
            w_reject = 1'b1;
          end
        end else if (w_let) begin
          if (w_len8) w_state_nxt = DISCARD;
          else        w_store     = 1'b1;
        end else if (w_bad) begin
          w_state_nxt = DISCARD;
        end
      end
      DISCARD: begin
        if (w_term) begin
          w_reject    = 1'b1;
          w_state_nxt = COLLECT;
        end
      end
      EMIT:    w_state_nxt = GAP;
      default: w_state_nxt = COLLECT;
    endcase
  end

  // The word is captured on the terminator edge so the strobe is visible during EMIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= COLLECT;
      r_count <= '0;
      r_nib   <= '0;
      r_code  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_reject;
      if (w_store) begin
        r_nib[r_count[2:0]] <= w_lookup[3:0];
        r_count             <= r_count + 4'd1;
      end else if (w_reject || (r_state == GAP)) begin
        r_count <= '0;
      end
      if (w_load) begin
        r_code[37:35]           <= '0;
        r_code[STROBE]          <= 1'b1;
        r_code[ENABLE]          <= 1'b1;
        r_code[CMP_EN]          <= w_len8;
        r_code[ADDR_HI:ADDR_LO] <= w_addr;
        r_code[CMP_HI:CMP_LO]   <= w_cmp;
        r_code[REPL_HI:REPL_LO] <= w_repl;
      end else if (r_state == EMIT) begin
        r_code[STROBE] <= 1'b0;
      end
    end
  end

  assign code = r_code;
  assign err  = r_err;
  assign busy = (r_count != '0) || (r_state != COLLECT);

`ifdef GENIE_DEC_STATS_EN
  logic [7:0] r_n_acc, r_n_rej;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_n_acc <= '0;
      r_n_rej <= '0;
    end else begin
      if ((r_state == EMIT) && (r_n_acc != '1)) r_n_acc <= r_n_acc + 8'd1;
      if (r_err && (r_n_rej != '1))             r_n_rej <= r_n_rej + 8'd1;
    end
  end

  assign n_accepted = r_n_acc;
  assign n_rejected = r_n_rej;
`endif

endmodule

// File: tb/tb_genie_code_decoder.sv
// Directed bench for genie_code_decoder: a stream-level reference model checked
// every cycle, plus literal field checks on the captured strobe words.
module tb_genie_code_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        chr_valid = 1'b0;
  logic [7:0]  chr_data = 8'h00;
  logic        flush = 1'b0;
  logic        chr_ready, busy, err;
  logic [37:0] code;
`ifdef GENIE_DEC_STATS_EN
  logic [7:0]  n_accepted, n_rejected;
`endif

  genie_code_decoder #(.ADDR_BASE(16'h8000)) dut (
    .clk       (clk),
    .reset     (reset),
    .chr_valid (chr_valid),
    .chr_data  (chr_data),
    .chr_ready (chr_ready),
    .flush     (flush),
    .code      (code),
    .busy      (busy),
    .err       (err)
`ifdef GENIE_DEC_STATS_EN
    ,
    .n_accepted(n_accepted),
    .n_rejected(n_rejected)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  string map = "APZLGITYEOXUKSVN";

  function automatic int letter_val(input logic [7:0] c);
    logic [7:0] u;
    u = ((c >= 8'h61) && (c <= 8'h7A)) ? (c - 8'h20) : c;
    for (int i = 0; i < 16; i++)
      if (8'(map[i]) == u) return i;
    return -1;
  endfunction

  function automatic bit term_char(input logic [7:0] c);
    return (c == 0) || (c == 10) || (c == 13) || (c == 32) || (c == 44) || (c == 59);
  endfunction

  function automatic logic [37:0] model_word(input int n[8], input bit len8);
    int a, r, cp, l;
    l  = len8 ? n[7] : n[5];
    a  = 'h8000 + ((n[3] % 8) << 12) + ((n[5] % 8) << 8) + ((n[4] / 8) << 11)
       + ((n[2] % 8) << 4) + ((n[1] / 8) << 7) + (n[4] % 8) + ((n[3] / 8) << 3);
    r  = ((n[1] % 8) << 4) + ((n[0] / 8) << 7) + (n[0] % 8) + ((l / 8) << 3);
    cp = len8 ? (((n[7] % 8) << 4) + ((n[6] / 8) << 7) + (n[6] % 8) + ((n[5] / 8) << 3)) : 0;
    return {3'b000, 1'b1, 1'b1, len8, a[15:0], cp[7:0], r[7:0]};
  endfunction

  int          m_let[$];
  bit          m_bad = 1'b0;
  int          m_phase = 0;
  logic [37:0] m_code = '0;
  bit          m_err = 1'b0;

  always @(posedge clk) begin
    bit new_err, term;
    int v;
    int nb[8];
    new_err = 1'b0;
    if (reset) begin
      m_let.delete();
      m_bad   = 1'b0;
      m_phase = 0;
      m_code  = '0;
    end else if (m_phase == 1) begin
      m_code[34] = 1'b0;
      m_phase    = 2;
    end else if (m_phase == 2) begin
      m_let.delete();
      m_phase = 0;
    end else begin
      term = chr_valid ? term_char(chr_data) : flush;
      if (term) begin
        if (m_bad || (m_let.size() != 0 && m_let.size() != 6 && m_let.size() != 8)) begin
          new_err = 1'b1;
          m_bad   = 1'b0;
          m_let.delete();
        end else if (m_let.size() != 0) begin
          for (int i = 0; i < 8; i++) nb[i] = (i < m_let.size()) ? m_let[i] : 0;
          m_code  = model_word(nb, m_let.size() == 8);
          m_phase = 1;
        end
      end else if (chr_valid) begin
        v = letter_val(chr_data);
        if (v >= 0) begin
          if (!m_bad) begin
            if (m_let.size() == 8) m_bad = 1'b1;
            else m_let.push_back(v);
          end
        end else if (chr_data != 8'h2D) begin
          m_bad = 1'b1;
        end
      end
    end
    m_err = new_err;
  end

  // ---------------- compare process ----------------
  bit          started = 1'b0;
  int          cyc = 0, n_strobe = 0, n_err = 0, n_consec = 0;
  int          last_strobe = -100, min_gap = 1000;
  bit          prev_strobe = 1'b0;
  logic [37:0] last_word = '0;

  always @(negedge clk) begin
    if (started) begin
      check("code", 64'(code), 64'(m_code));
      check("err", 64'(err), 64'(m_err));
      check("busy", 64'(busy), 64'((m_let.size() != 0) || m_bad || (m_phase != 0)));
      check("chr_ready", 64'(chr_ready), 64'(m_phase == 0));
      if (code[34] === 1'b1) begin
        n_strobe++;
        if (prev_strobe) n_consec++;
        if (cyc - last_strobe < min_gap) min_gap = cyc - last_strobe;
        last_strobe = cyc;
        last_word   = code;
      end
      if (err === 1'b1) n_err++;
      prev_strobe = (code[34] === 1'b1);
      cyc++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_byte(input logic [7:0] c);
    bit done;
    int k;
    done = 1'b0;
    k    = 0;
    chr_valid = 1'b1;
    chr_data  = c;
    while (!done) begin
      @(negedge clk);
      done = (chr_ready === 1'b1);
      @(posedge clk);
      #1;
      k++;
      if (!done && k > 20) begin
        check("ready_timeout", 64'(0), 64'(1));
        done = 1'b1;
      end
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    chr_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int s0, e0;
    string bad_codes[4];
    bad_codes[0] = "SXIOP\n";
    bad_codes[1] = "SXIOPOA\n";
    bad_codes[2] = "SXIOPOAAA\n";
    bad_codes[3] = "SXIQPO\n";

    @(posedge clk);
    started = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_code", 64'(code), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_ready", 64'(chr_ready), 64'(1));
    check("rst_err", 64'(err), 64'(0));
    reset = 1'b0;
    idle(2);

    // 6-letter code
    s0 = n_strobe; e0 = n_err;
    send_str("SXIOPO\n");
    idle(4);
    check("t1_strobes", 64'(n_strobe - s0), 64'(1));
    check("t1_errs", 64'(n_err - e0), 64'(0));
    check("t1_addr", 64'(last_word[31:16]), 64'(16'h91D9));
    check("t1_repl", 64'(last_word[7:0]), 64'(8'hAD));
    check("t1_cmp", 64'(last_word[15:8]), 64'(0));
    check("t1_cmpen", 64'(last_word[32]), 64'(0));
    check("t1_enable", 64'(last_word[33]), 64'(1));

    // 8-letter code
    s0 = n_strobe;
    send_str("PPPPPPPP,");
    idle(4);
    check("t2_strobes", 64'(n_strobe - s0), 64'(1));
    check("t2_addr", 64'(last_word[31:16]), 64'(16'h9111));
    check("t2_repl", 64'(last_word[7:0]), 64'(8'h11));
    check("t2_cmp", 64'(last_word[15:8]), 64'(8'h11));
    check("t2_cmpen", 64'(last_word[32]), 64'(1));

    // lower case with dash, terminated by flush
    s0 = n_strobe;
    send_str("sxio-po");
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    idle(4);
    check("t3_strobes", 64'(n_strobe - s0), 64'(1));
    check("t3_word", 64'(last_word), 64'(38'h0691D900AD));
    check("t3_busy", 64'(busy), 64'(0));

    // malformed codes
    for (int i = 0; i < 4; i++) begin
      s0 = n_strobe; e0 = n_err;
      send_str(bad_codes[i]);
      idle(3);
      check("t4_err_pulses", 64'(n_err - e0), 64'(1));
      check("t4_strobes", 64'(n_strobe - s0), 64'(0));
      check("t4_code_kept", 64'(code[31:0]), 64'(32'h91D900AD));
    end

    // back-to-back with valid held high
    s0 = n_strobe; min_gap = 1000;
    send_str("SXIOPO,PPPPPPPP,");
    idle(4);
    check("t5_strobes", 64'(n_strobe - s0), 64'(2));
    check("t5_gap_ok", 64'(min_gap >= 2), 64'(1));
    check("t5_no_double", 64'(n_consec), 64'(0));
    check("t5_addr", 64'(last_word[31:16]), 64'(16'h9111));

    // reset mid-code
    e0 = n_err; s0 = n_strobe;
    send_str("SXI");
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check("t6_busy_after_rst", 64'(busy), 64'(0));
    send_str("PPPPPP\n");
    idle(4);
    check("t6_strobes", 64'(n_strobe - s0), 64'(1));
    check("t6_addr", 64'(last_word[31:16]), 64'(16'h9111));
    check("t6_repl", 64'(last_word[7:0]), 64'(8'h11));
    check("t6_cmpen", 64'(last_word[32]), 64'(0));
    check("t6_errs", 64'(n_err - e0), 64'(0));

    s0 = n_strobe; e0 = n_err;
    send_str("\n\n");
    idle(3);
    check("t7_strobes", 64'(n_strobe - s0), 64'(0));
    check("t7_errs", 64'(n_err - e0), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
